// File: rtl/spectral_flux_engine_if.sv
// Bin stream into the spectral-flux engine and the per-frame flux/beat results out of it.
// The producer (FFT magnitude stage or bench) uses master; the engine uses slave.
interface spectral_flux_engine_if #(
  parameter int W               = 16,
  parameter int MAX_FLUX_LENGTH = 32
);
  logic                       mag_valid;
  logic [W-1:0]               mag_sq;
  logic [MAX_FLUX_LENGTH-1:0] flux_value;
  logic                       flux_valid;
  logic                       frame_done;
  logic                       beat_valid;
  logic [MAX_FLUX_LENGTH-1:0] flux_low;
  logic [MAX_FLUX_LENGTH-1:0] flux_mid;
  logic [MAX_FLUX_LENGTH-1:0] flux_high;
  logic [MAX_FLUX_LENGTH-1:0] flux_accum;

  modport master (
    output mag_valid, mag_sq,
    input  flux_value, flux_valid, frame_done, beat_valid,
    input  flux_low, flux_mid, flux_high, flux_accum
  );

  modport slave (
    input  mag_valid, mag_sq,
    output flux_value, flux_valid, frame_done, beat_valid,
    output flux_low, flux_mid, flux_high, flux_accum
  );
endinterface

// File: rtl/spectral_flux_engine.sv
// Spectral-flux onset detector: half-wave-rectified bin-to-bin increase summed per frame
// into low/mid/high bands, plus an adaptive-threshold beat flag.
module spectral_flux_engine #(
  parameter int W               = 16,
  parameter int N               = 8,
  parameter int MAX_FLUX_LENGTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  spectral_flux_engine_if.slave bus
);

  localparam int ML = MAX_FLUX_LENGTH;
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LOW_END  = BW'(N / 4);
  localparam logic [BW-1:0] MID_END  = BW'(N / 2);
  localparam logic [BW-1:0] LAST_BIN = BW'(N - 1);

  function automatic logic [W-1:0] rectify(input logic [W-1:0] cur, input logic [W-1:0] old,
                                           input logic primed);
    return (primed && (cur > old)) ? (cur - old) : '0;
  endfunction

  function automatic logic [ML-1:0] sat_add(input logic [ML-1:0] acc, input logic [W-1:0] d);
    logic [ML:0] s;
    s = {1'b0, acc} + {{(ML + 1 - W){1'b0}}, d};
    return s[ML] ? {ML{1'b1}} : s[ML-1:0];
  endfunction

  // Threshold avg*1.5 is formed two bits wider so it can never wrap.
  function automatic logic beat_detect(input logic primed, input logic [ML-1:0] f,
                                       input logic [ML-1:0] avg);
    logic [ML+1:0] thr;
    thr = {2'b00, avg} + {2'b00, avg >> 1};
    return primed && (f != '0) && ({2'b00, f} > thr);
  endfunction

  // 7/8 of the old average plus 1/8 of the new flux never exceeds the register range.
  function automatic logic [ML-1:0] avg_next(input logic [ML-1:0] avg, input logic [ML-1:0] f);
    return avg - (avg >> 3) + (f >> 3);
  endfunction

  logic [BW-1:0] bin_q, bin_d;
  logic [W-1:0]  prev_q [N];
  logic [W-1:0]  prev_d [N];
  logic [ML-1:0] tot_q, tot_d, low_q, low_d, mid_q, mid_d, high_q, high_d;
  logic [ML-1:0] flux_value_q, flux_value_d, flux_low_q, flux_low_d;
  logic [ML-1:0] flux_mid_q, flux_mid_d, flux_high_q, flux_high_d;
  logic [ML-1:0] avg_q, avg_d;
  logic          flux_valid_q, flux_valid_d, frame_done_q, frame_done_d;
  logic          beat_valid_q, beat_valid_d, primed_q, primed_d;

  logic [W-1:0]  d;
  logic          is_low, is_mid;
  logic [ML-1:0] tot_sum, low_sum, mid_sum, high_sum;

  always_comb begin
    bin_d        = bin_q;
    prev_d       = prev_q;
    tot_d        = tot_q;
    low_d        = low_q;
    mid_d        = mid_q;
    high_d       = high_q;
    flux_value_d = flux_value_q;
    flux_low_d   = flux_low_q;
    flux_mid_d   = flux_mid_q;
    flux_high_d  = flux_high_q;
    avg_d        = avg_q;
    primed_d     = primed_q;
    flux_valid_d = 1'b0;
    frame_done_d = 1'b0;
    beat_valid_d = 1'b0;

    d        = rectify(bus.mag_sq, prev_q[bin_q], primed_q);
    is_low   = bin_q < LOW_END;
    is_mid   = !is_low && (bin_q < MID_END);
    tot_sum  = sat_add(tot_q, d);
    low_sum  = is_low ? sat_add(low_q, d) : low_q;
    mid_sum  = is_mid ? sat_add(mid_q, d) : mid_q;
    high_sum = (!is_low && !is_mid) ? sat_add(high_q, d) : high_q;

    if (bus.mag_valid) begin
      prev_d[bin_q] = bus.mag_sq;
      if (bin_q == LAST_BIN) begin
        // Frame end: publish the sums including this bin and start the next frame from zero.
        flux_value_d = tot_sum;
        flux_low_d   = low_sum;
        flux_mid_d   = mid_sum;
        flux_high_d  = high_sum;
        tot_d        = '0;
        low_d        = '0;
        mid_d        = '0;
        high_d       = '0;
        flux_valid_d = 1'b1;
        frame_done_d = 1'b1;
        beat_valid_d = beat_detect(primed_q, tot_sum, avg_q);
        avg_d        = avg_next(avg_q, tot_sum);
        primed_d     = 1'b1;
        bin_d        = '0;
      end else begin
        tot_d  = tot_sum;
        low_d  = low_sum;
        mid_d  = mid_sum;
        high_d = high_sum;
        bin_d  = bin_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q        <= '0;
      for (int i = 0; i < N; i++) prev_q[i] <= '0;
      tot_q        <= '0;
      low_q        <= '0;
      mid_q        <= '0;
      high_q       <= '0;
      flux_value_q <= '0;
      flux_low_q   <= '0;
      flux_mid_q   <= '0;
      flux_high_q  <= '0;
      avg_q        <= '0;
      primed_q     <= 1'b0;
      flux_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      beat_valid_q <= 1'b0;
    end else begin
      bin_q        <= bin_d;
      prev_q       <= prev_d;
      tot_q        <= tot_d;
      low_q        <= low_d;
      mid_q        <= mid_d;
      high_q       <= high_d;
      flux_value_q <= flux_value_d;
      flux_low_q   <= flux_low_d;
      flux_mid_q   <= flux_mid_d;
      flux_high_q  <= flux_high_d;
      avg_q        <= avg_d;
      primed_q     <= primed_d;
      flux_valid_q <= flux_valid_d;
      frame_done_q <= frame_done_d;
      beat_valid_q <= beat_valid_d;
    end
  end

  assign bus.flux_value = flux_value_q;
  assign bus.flux_low   = flux_low_q;
  assign bus.flux_mid   = flux_mid_q;
  assign bus.flux_high  = flux_high_q;
  assign bus.flux_accum = tot_q;
  assign bus.flux_valid = flux_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.beat_valid = beat_valid_q;

endmodule

// File: tb/tb_spectral_flux_engine.sv
// Bench for spectral_flux_engine: directed and random frames against a plain-arithmetic model.
module tb_spectral_flux_engine;

  localparam int  W    = 16;
  localparam int  N    = 8;
  localparam int  ML   = 32;
  localparam longint MAXV = (64'd1 << ML) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spectral_flux_engine_if #(.W(W), .MAX_FLUX_LENGTH(ML)) bus ();

  spectral_flux_engine #(.W(W), .N(N), .MAX_FLUX_LENGTH(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state
  longint prev_m [N];
  bit     primed_m;
  longint avg_m;
  int     bin_m;
  longint acc_m, low_m, mid_m, high_m;
  longint fv_m, fl_m, fm_m, fh_m;
  bit     beat_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) prev_m[i] = 0;
    primed_m = 0; avg_m = 0; bin_m = 0;
    acc_m = 0; low_m = 0; mid_m = 0; high_m = 0;
    fv_m = 0; fl_m = 0; fm_m = 0; fh_m = 0; beat_m = 0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      bus.mag_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_accum", bus.flux_accum, acc_m);
      chk("idle_fvalid", bus.flux_valid, 0);
    end
  endtask

  task automatic send_bin(input int v, input int gap);
    longint dd, f;
    idle(gap);
    @(negedge clk);
    bus.mag_valid = 1'b1;
    bus.mag_sq    = W'(v);
    dd = (primed_m && v > prev_m[bin_m]) ? v - prev_m[bin_m] : 0;
    prev_m[bin_m] = v;
    acc_m = sat(acc_m + dd);
    if (bin_m < N / 4)      low_m  = sat(low_m + dd);
    else if (bin_m < N / 2) mid_m  = sat(mid_m + dd);
    else                    high_m = sat(high_m + dd);
    @(posedge clk); #1;
    if (bin_m == N - 1) begin
      f      = acc_m;
      beat_m = primed_m && f > 0 && f > avg_m + avg_m / 2;
      avg_m  = avg_m - avg_m / 8 + f / 8;
      primed_m = 1;
      fv_m = f; fl_m = low_m; fm_m = mid_m; fh_m = high_m;
      acc_m = 0; low_m = 0; mid_m = 0; high_m = 0;
      bin_m = 0;
      chk("end_fvalid", bus.flux_valid, 1);
      chk("end_fdone", bus.frame_done, 1);
      chk("end_beat", bus.beat_valid, beat_m);
      chk("end_flux", bus.flux_value, fv_m);
      chk("end_low", bus.flux_low, fl_m);
      chk("end_mid", bus.flux_mid, fm_m);
      chk("end_high", bus.flux_high, fh_m);
      chk("end_accum", bus.flux_accum, 0);
    end else begin
      bin_m++;
      chk("bin_fvalid", bus.flux_valid, 0);
      chk("bin_beat", bus.beat_valid, 0);
      chk("bin_accum", bus.flux_accum, acc_m);
      chk("hold_flux", bus.flux_value, fv_m);
    end
  endtask

  task automatic send_frame(input int v [N], input int max_gap);
    for (int i = 0; i < N; i++) send_bin(v[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  int fr_primer [N] = '{500, 500, 500, 500, 500, 500, 500, 500};
  int fr_ramp   [N] = '{100, 150, 200, 250, 300, 350, 400, 450};
  int fr_hit    [N] = '{100, 700, 1500, 100, 700, 1500, 100, 700};
  int fr_rand   [N];

  initial begin
    reset = 1'b0;
    bus.mag_valid = 1'b0;
    bus.mag_sq    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flux", bus.flux_value, 0);
    chk("rst_accum", bus.flux_accum, 0);
    chk("rst_fvalid", bus.flux_valid, 0);
    chk("rst_beat", bus.beat_valid, 0);
    @(negedge clk);
    reset = 1'b1;

    send_frame(fr_primer, 0);
    idle(1);
    send_frame(fr_ramp, 0);
    send_frame(fr_hit, 0);
    chk("hit_low", fl_m, 550);
    chk("hit_mid", fm_m, 1300);
    send_frame(fr_hit, 0);
    send_frame(fr_ramp, 0);
    send_frame(fr_hit, 3);
    idle(2);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) fr_rand[i] = int'($urandom_range(0, (1 << W) - 1));
      send_frame(fr_rand, (k % 2) * 2);
    end
    send_frame(fr_ramp, 0);
    send_frame(fr_hit, 0);

    for (int i = 0; i < 4; i++) send_bin(fr_hit[i], 0);
    #2;
    reset = 1'b0;
    bus.mag_valid = 1'b0;
    #1;
    model_reset();
    chk("async_accum", bus.flux_accum, 0);
    chk("async_flux", bus.flux_value, 0);
    chk("async_high", bus.flux_high, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    send_frame(fr_ramp, 0);
    send_frame(fr_hit, 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
